truth_table_lut: RTL and testbench

TRUTH_TABLE_LUT -- requirements
Module: truth_table_lut

---
 rtl/truth_table_pkg.sv | 19 +
 rtl/truth_table_lut_if.sv | 29 ++
 rtl/truth_table_loader.sv | 85 ++++++++
 rtl/truth_table_lut.sv | 142 ++++++++++++++
 tb/tb_truth_table_lut.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/truth_table_pkg.sv
// Shared types and size helpers for the truth-table LUT: FSM state encoding
// and the table-bits / config-beats derivations used by top and loader.
package truth_table_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_LOAD  = 2'd1,
        ST_READY = 2'd2
    } lut_state_e;

    function automatic int tbl_bits(input int n_in);
        return 1 << n_in;
    endfunction

    function automatic int tbl_beats(input int n_in, input int cfg_w);
        return (tbl_bits(n_in) + cfg_w - 1) / cfg_w;
    endfunction

endpackage

// File: rtl/truth_table_lut_if.sv
// Config, input and result channels of the truth-table LUT.
// The master side drives config beats and input vectors and consumes results.
interface truth_table_lut_if #(
    parameter int N_IN  = 3,
    parameter int CFG_W = 8
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CFG_W-1:0] cfg_data;
    logic             cfg_last;
    logic             in_valid;
    logic             in_ready;
    logic [N_IN-1:0]  in_vec;
    logic             out_valid;
    logic             out_ready;
    logic             out;
    logic             loaded;
    logic             cfg_err;

    modport master (
        output cfg_valid, cfg_data, cfg_last, in_valid, in_vec, out_ready,
        input  cfg_ready, in_ready, out_valid, out, loaded, cfg_err
    );

    modport slave (
        input  cfg_valid, cfg_data, cfg_last, in_valid, in_vec, out_ready,
        output cfg_ready, in_ready, out_valid, out, loaded, cfg_err
    );
endinterface

// File: rtl/truth_table_loader.sv
// Config loader: gathers beats MSB-chunk first into a staging register and
// flags commit (final beat with cfg_last) or abort (cfg_last on the wrong beat).
module truth_table_loader
    import truth_table_pkg::*;
#(
    parameter int N_IN  = 3,
    parameter int CFG_W = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      beat_fire,
    input  logic [CFG_W-1:0]          cfg_data,
    input  logic                      cfg_last,
    output logic                      commit,
    output logic                      abort,
    output logic [tbl_bits(N_IN)-1:0] new_table
);
    localparam int T     = tbl_bits(N_IN);
    localparam int B     = tbl_beats(N_IN, CFG_W);
    localparam int CNT_W = (B > 1) ? $clog2(B) : 1;

    logic [CNT_W-1:0] beat_q, beat_d;
    logic             is_final;

    // Upper bits of the final beat are don't-care when T is not a multiple of CFG_W.
    wire cfg_data_unused = ^cfg_data;

    assign is_final = (beat_q == CNT_W'(B - 1));
    assign commit   = beat_fire && cfg_last && is_final;
    assign abort    = beat_fire && (cfg_last != is_final);

    // NOTE: every always_comb output gets a default first, so no path infers a latch.
    always_comb begin
        beat_d = beat_q;
        if (commit || abort) begin
            beat_d = '0;
        end else if (beat_fire) begin
            beat_d = beat_q + 1'b1;
        end
    end

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            beat_q <= '0;
        end else begin
            beat_q <= beat_d;
        end
    end

    generate
        if (B == 1) begin : g_single
            assign new_table = cfg_data[T-1:0];
        end else begin : g_multi
            localparam int SW = (B - 1) * CFG_W;
            localparam int R  = T - SW;

            logic [SW-1:0]       stg_q, stg_d;
            logic [SW+CFG_W-1:0] shifted;

            assign shifted = {stg_q, cfg_data};

            always_comb begin
                stg_d = stg_q;
                if (commit || abort) begin
                    stg_d = '0;
                end else if (beat_fire) begin
                    stg_d = shifted[SW-1:0];
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    stg_q <= '0;
                end else begin
                    stg_q <= stg_d;
                end
            end

            // The final beat supplies only the low R bits of the table.
            assign new_table = {stg_q, cfg_data[R-1:0]};
        end
    endgenerate

endmodule

// File: rtl/truth_table_lut.sv
// Reloadable N_IN-input truth-table LUT with a one-cycle registered result.
// Define LUT_FILTER_EN to add a FILTER_LEN-deep agreement filter on the output.
module truth_table_lut
    import truth_table_pkg::*;
#(
    parameter int N_IN       = 3,
    parameter int CFG_W      = 8,
    parameter int FILTER_LEN = 4
) (
    input logic              clk,
    input logic              reset,
    truth_table_lut_if.slave bus
);
    localparam int T = tbl_bits(N_IN);

    lut_state_e      state_q;
    logic [T-1:0]    active_q, active_d;
    logic [T-1:0]    new_table;
    logic            loaded_q, loaded_d;
    logic            cfg_err_q, cfg_err_d;
    logic            out_q, out_d;
    logic            out_valid_q, out_valid_d;
    logic            cfg_fire, in_fire, commit, abort;
    logic            raw, eval_out;
    logic [N_IN-1:0] idx;

    assign bus.cfg_ready = (state_q != ST_READY) || !out_valid_q;
    assign bus.in_ready  = (state_q == ST_READY) && !bus.cfg_valid &&
                           (!out_valid_q || bus.out_ready);
    assign cfg_fire      = bus.cfg_valid && bus.cfg_ready;
    assign in_fire       = bus.in_valid && bus.in_ready;

    truth_table_loader #(.N_IN(N_IN), .CFG_W(CFG_W)) u_loader (
        .clk       (clk),
        .reset     (reset),
        .beat_fire (cfg_fire),
        .cfg_data  (bus.cfg_data),
        .cfg_last  (bus.cfg_last),
        .commit    (commit),
        .abort     (abort),
        .new_table (new_table)
    );

    // MSB-first table: row i lives at bit T-1-i, which is simply ~i.
    assign idx = ~bus.in_vec;
    assign raw = active_q[idx];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_EMPTY;
        end else if (cfg_fire) begin
            if (commit || abort) begin
                state_q <= (commit || loaded_q) ? ST_READY : ST_EMPTY;
            end else begin
                state_q <= ST_LOAD;
            end
        end
    end

`ifdef LUT_FILTER_EN
    localparam int FC_W = $clog2(FILTER_LEN + 1);

    logic [FC_W-1:0] fcnt_q, fcnt_d;
    logic            filt_out;

    // Count consecutive lookups disagreeing with out; flip once FILTER_LEN is reached.
    always_comb begin
        fcnt_d   = fcnt_q;
        filt_out = out_q;
        if (commit) begin
            fcnt_d = '0;
        end else if (in_fire) begin
            if (raw == out_q) begin
                fcnt_d = '0;
            end else if (fcnt_q == FC_W'(FILTER_LEN - 1)) begin
                fcnt_d   = '0;
                filt_out = raw;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fcnt_q <= '0;
        end else begin
            fcnt_q <= fcnt_d;
        end
    end

    assign eval_out = filt_out;
`else
    wire [31:0] filter_len_unused = 32'(FILTER_LEN);

    assign eval_out = raw;
`endif

    always_comb begin
        active_d    = active_q;
        loaded_d    = loaded_q;
        cfg_err_d   = cfg_err_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        if (commit) begin
            active_d = new_table;
            loaded_d = 1'b1;
        end
        if (abort) begin
            cfg_err_d = 1'b1;
        end
        if (in_fire) begin
            out_valid_d = 1'b1;
            out_d       = eval_out;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // NOTE: the table is a register, not a RAM, so it is reset: lookups before any load read 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            active_q    <= '0;
            loaded_q    <= 1'b0;
            cfg_err_q   <= 1'b0;
            out_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            active_q    <= active_d;
            loaded_q    <= loaded_d;
            cfg_err_q   <= cfg_err_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.loaded    = loaded_q;
    assign bus.cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_truth_table_lut.sv
// Directed bench for truth_table_lut: a 3-input and a 4-input instance with
// hand-computed expectations; the LUT_FILTER_EN build runs the filter sequence.
module tb_truth_table_lut;

    logic clk = 1'b0;
    logic rst3, rst4;
    int   n_vec  = 0;
    int   n_miss = 0;

    always #5 clk = ~clk;

    truth_table_lut_if #(.N_IN(3), .CFG_W(8)) b3 ();
    truth_table_lut_if #(.N_IN(4), .CFG_W(8)) b4 ();

    truth_table_lut #(.N_IN(3), .CFG_W(8), .FILTER_LEN(4)) dut3 (
        .clk   (clk),
        .reset (rst3),
        .bus   (b3)
    );

    truth_table_lut #(.N_IN(4), .CFG_W(8), .FILTER_LEN(4)) dut4 (
        .clk   (clk),
        .reset (rst4),
        .bus   (b4)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic beat3(input logic [7:0] d, input logic last);
        b3.cfg_valid = 1'b1;
        b3.cfg_data  = d;
        b3.cfg_last  = last;
        tick();
        b3.cfg_valid = 1'b0;
        b3.cfg_last  = 1'b0;
    endtask

    task automatic beat4(input logic [7:0] d, input logic last);
        b4.cfg_valid = 1'b1;
        b4.cfg_data  = d;
        b4.cfg_last  = last;
        tick();
        b4.cfg_valid = 1'b0;
        b4.cfg_last  = 1'b0;
    endtask

    task automatic eval3(input logic [2:0] v, input logic exp, input string tag);
        b3.in_valid  = 1'b1;
        b3.in_vec    = v;
        b3.out_ready = 1'b1;
        tick();
        b3.in_valid  = 1'b0;
        check(tag, {b3.out_valid, b3.out}, {1'b1, exp});
    endtask

    task automatic eval4(input logic [3:0] v, input logic exp, input string tag);
        b4.in_valid  = 1'b1;
        b4.in_vec    = v;
        b4.out_ready = 1'b1;
        tick();
        b4.in_valid  = 1'b0;
        check(tag, {b4.out_valid, b4.out}, {1'b1, exp});
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit exp_sweep [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

        b3.cfg_valid = 1'b0; b3.cfg_data = '0; b3.cfg_last = 1'b0;
        b3.in_valid  = 1'b0; b3.in_vec   = '0; b3.out_ready = 1'b0;
        b4.cfg_valid = 1'b0; b4.cfg_data = '0; b4.cfg_last = 1'b0;
        b4.in_valid  = 1'b0; b4.in_vec   = '0; b4.out_ready = 1'b0;
        rst3 = 1'b1;
        rst4 = 1'b1;
        tick();
        tick();
        rst3 = 1'b0;
        rst4 = 1'b0;
        #1;

        // Reset state: {out_valid, out, loaded, cfg_err, in_ready, cfg_ready}
        check("rst3_state", {b3.out_valid, b3.out, b3.loaded, b3.cfg_err, b3.in_ready, b3.cfg_ready}, 8'b000001);
        check("rst4_state", {b4.out_valid, b4.out, b4.loaded, b4.cfg_err, b4.in_ready, b4.cfg_ready}, 8'b000001);

        // Single-beat load of 0x13 on the 3-input instance
        beat3(8'h13, 1'b1);
        #1;
        check("load13_loaded", {b3.loaded, b3.cfg_err}, 8'b10);
        check("load13_in_ready", b3.in_ready, 1'b1);

`ifdef LUT_FILTER_EN
        eval3(3'b000, 1'b0, "filt_a0");
        eval3(3'b011, 1'b0, "filt_a1");
        eval3(3'b011, 1'b0, "filt_a2");
        eval3(3'b011, 1'b0, "filt_a3");
        eval3(3'b011, 1'b1, "filt_a4");
        rst3 = 1'b1;
        tick();
        rst3 = 1'b0;
        check("filt_rst_out", {b3.out_valid, b3.out}, 8'b00);
        beat3(8'h13, 1'b1);
        eval3(3'b011, 1'b0, "filt_b1");
        eval3(3'b011, 1'b0, "filt_b2");
        eval3(3'b000, 1'b0, "filt_b3_restart");
        eval3(3'b011, 1'b0, "filt_b4");
        eval3(3'b011, 1'b0, "filt_b5");
        eval3(3'b011, 1'b0, "filt_b6");
        eval3(3'b011, 1'b1, "filt_b7");
`else
        // Full-throughput sweep of all eight rows
        b3.out_ready = 1'b1;
        b3.in_valid  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            b3.in_vec = 3'(i);
            #1;
            check("sweep_in_ready", b3.in_ready, 1'b1);
            tick();
            check("sweep_out", {b3.out_valid, b3.out}, {1'b1, exp_sweep[i]});
        end
        b3.in_valid = 1'b0;
        tick();
        check("drain_out_valid", b3.out_valid, 1'b0);

        // Backpressure: one result held while out_ready is low
        b3.out_ready = 1'b0;
        b3.in_valid  = 1'b1;
        b3.in_vec    = 3'b011;
        tick();
        check("bp_first", {b3.out_valid, b3.out}, 8'b11);
        b3.in_vec = 3'b100;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_in_ready", b3.in_ready, 1'b0);
            check("bp_cfg_ready", b3.cfg_ready, 1'b0);
            tick();
            check("bp_hold", {b3.out_valid, b3.out}, 8'b11);
        end
        b3.out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", b3.in_ready, 1'b1);
        tick();
        check("bp_next", {b3.out_valid, b3.out}, 8'b10);
        b3.in_valid = 1'b0;
        tick();
        check("bp_drain", b3.out_valid, 1'b0);

        // Config wins over a simultaneous input in READY
        b3.cfg_valid = 1'b1;
        b3.cfg_data  = 8'hEC;
        b3.cfg_last  = 1'b1;
        b3.in_valid  = 1'b1;
        b3.in_vec    = 3'b000;
        #1;
        check("both_in_ready", b3.in_ready, 1'b0);
        check("both_cfg_ready", b3.cfg_ready, 1'b1);
        tick();
        b3.cfg_valid = 1'b0;
        b3.cfg_last  = 1'b0;
        b3.in_valid  = 1'b0;
        check("both_no_result", b3.out_valid, 1'b0);
        eval3(3'b000, 1'b1, "reload_row0");
        eval3(3'b011, 1'b0, "reload_row3");
`endif

        // Reset in the middle of a two-beat load on the 4-input instance
        beat4(8'h12, 1'b0);
        #1;
        check("load_in_ready", {b4.in_ready, b4.cfg_ready, b4.loaded}, 8'b010);
        b4.in_valid = 1'b1;
        rst4 = 1'b1;
        tick();
        rst4 = 1'b0;
        #1;
        check("midrst_state", {b4.out_valid, b4.out, b4.loaded, b4.cfg_err, b4.in_ready}, 8'b00000);
        b4.in_valid = 1'b0;
        beat4(8'h34, 1'b1);
        check("midrst_no_commit", {b4.loaded, b4.cfg_err}, 8'b01);

        // cfg_err clears only through reset
        rst4 = 1'b1;
        tick();
        rst4 = 1'b0;
        check("err_cleared", b4.cfg_err, 1'b0);

        // Two-beat load of 0x1234
        beat4(8'h12, 1'b0);
        beat4(8'h34, 1'b1);
        #1;
        check("load1234", {b4.loaded, b4.cfg_err, b4.in_ready}, 8'b101);
`ifndef LUT_FILTER_EN
        eval4(4'd0,  1'b0, "t1234_row0");
        eval4(4'd3,  1'b1, "t1234_row3");
        eval4(4'd6,  1'b1, "t1234_row6");
        eval4(4'd13, 1'b1, "t1234_row13");
        eval4(4'd15, 1'b0, "t1234_row15");
        b4.out_ready = 1'b1;
        tick();
`endif

        // Second beat without cfg_last aborts and keeps 0x1234 active
        beat4(8'hAB, 1'b0);
        #1;
        check("abort_mid_in_ready", b4.in_ready, 1'b0);
        beat4(8'hCD, 1'b0);
        #1;
        check("abort_flags", {b4.cfg_err, b4.loaded, b4.in_ready}, 8'b111);
`ifndef LUT_FILTER_EN
        eval4(4'd0, 1'b0, "kept_row0");
        eval4(4'd3, 1'b1, "kept_row3");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
